// File: rtl/wb_sequencer.sv
// Register-file write-back sequencer: merges ALU and queued load results into one
// registered write per cycle and tracks outstanding destinations for hazard detection.
module wb_sequencer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [4:0]                  ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    input  logic                        iss_valid,
    input  logic [4:0]                  iss_rd,
    input  logic [4:0]                  chk1_rg,
    input  logic [4:0]                  chk2_rg,
    output logic                        hazard,
    output logic [31:0]                 pend,
    output logic                        lq_full,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        w_en,
    output logic [4:0]                  write_rg,
    output logic [XLEN-1:0]             write_data
);

    localparam int unsigned PW = $clog2(LQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]      lq_rd_mem   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data_mem [LQ_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            enq;
    logic            deq;
    logic            sel_alu;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pend_nxt;
    logic            hit1;
    logic            hit2;

    // Readiness comes only from registered occupancy, never from a same-cycle dequeue
    assign lq_full  = (lq_count == CW'(LQ_DEPTH));
    assign ld_ready = !lq_full;

    // Source selection: ALU first, then queue head; x0 destinations are dropped
    always_comb begin
        enq       = ld_valid && ld_ready && (ld_rd != 5'd0);
        sel_alu   = alu_valid && (alu_rd != 5'd0);
        deq       = !sel_alu && (lq_count != CW'(0));
        sel_valid = sel_alu || deq;
        sel_rd    = sel_alu ? alu_rd : lq_rd_mem[rd_ptr];
        sel_data  = sel_alu ? alu_data : lq_data_mem[rd_ptr];
    end

    // Scoreboard update: clear on output-stage load, new issue overrides the clear
    always_comb begin
        pend_nxt = pend;
        if (sel_valid) begin
            pend_nxt[sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pend_nxt[iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Output-stage match covers the cycle before the regfile commits
    always_comb begin
        hit1   = (chk1_rg != 5'd0) && (pend[chk1_rg] || (w_en && (write_rg == chk1_rg)));
        hit2   = (chk2_rg != 5'd0) && (pend[chk2_rg] || (w_en && (write_rg == chk2_rg)));
        hazard = hit1 || hit2;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            lq_rd_mem[wr_ptr]   <= ld_rd;
            lq_data_mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            lq_count <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            lq_count <= lq_count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en       <= 1'b0;
            write_rg   <= 5'd0;
            write_data <= '0;
            pend       <= '0;
        end else begin
            pend <= pend_nxt;
            w_en <= sel_valid;
            if (sel_valid) begin
                write_rg   <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the write-back rules.
module tb_wb_sequencer;

    localparam int unsigned XLEN = 32;
    localparam int unsigned D    = 4;
    localparam int unsigned CW   = $clog2(D) + 1;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      chk1_rg;
    logic [4:0]      chk2_rg;
    logic            hazard;
    logic [31:0]     pend;
    logic            lq_full;
    logic [CW-1:0]   lq_count;
    logic            w_en;
    logic [4:0]      write_rg;
    logic [XLEN-1:0] write_data;

    wb_sequencer #(.XLEN(XLEN), .LQ_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk1_rg(chk1_rg), .chk2_rg(chk2_rg),
        .hazard(hazard), .pend(pend), .lq_full(lq_full), .lq_count(lq_count),
        .w_en(w_en), .write_rg(write_rg), .write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference state: architectural view of the queue, scoreboard and write port
    ent_t            m_q[$];
    logic [31:0]     m_pend;
    logic            m_wen;
    logic [4:0]      m_wrg;
    logic [XLEN-1:0] m_wdata;
    bit              last_acc;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_hazard();
        logic [4:0] c[2];
        bit h;
        c[0] = chk1_rg;
        c[1] = chk2_rg;
        h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (c[i] != 5'd0 && (m_pend[c[i]] || (m_wen && m_wrg == c[i])))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend  = '0;
        m_wen   = 1'b0;
        m_wrg   = 5'd0;
        m_wdata = '0;
    endtask

    task automatic model_step();
        bit   rdy;
        ent_t e;
        rdy = (m_q.size() < D);
        if (alu_valid && alu_rd != 5'd0) begin
            m_wen = 1'b1; m_wrg = alu_rd; m_wdata = alu_data;
            m_pend[alu_rd] = 1'b0;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_wen = 1'b1; m_wrg = e.rd; m_wdata = e.data;
            m_pend[e.rd] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        last_acc = ld_valid && rdy;
        if (last_acc && ld_rd != 5'd0) begin
            e.rd = ld_rd; e.data = ld_data;
            m_q.push_back(e);
        end
        if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
    endtask

    // One clock: combinational checks mid-cycle, register checks just after the edge
    task automatic tick();
        @(negedge clk); #1;
        check("hazard",   64'(hazard),   64'(exp_hazard()));
        check("ld_ready", 64'(ld_ready), 64'(m_q.size() < D));
        check("lq_full",  64'(lq_full),  64'(m_q.size() == D));
        model_step();
        @(posedge clk); #1;
        check("w_en",       64'(w_en),       64'(m_wen));
        check("write_rg",   64'(write_rg),   64'(m_wrg));
        check("write_data", 64'(write_data), 64'(m_wdata));
        check("pend",       64'(pend),       64'(m_pend));
        check("lq_count",   64'(lq_count),   64'(m_q.size()));
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
        chk1_rg = 5'd0; chk2_rg = 5'd0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        ld_valid = v; ld_rd = rd; ld_data = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_w_en"},     64'(w_en),     64'(0));
        check({tag, "_pend"},     64'(pend),     64'(0));
        check({tag, "_lq_count"}, 64'(lq_count), 64'(0));
        check({tag, "_ld_ready"}, 64'(ld_ready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] cnt_before;
        n_vec = 0; n_err = 0; last_acc = 1'b0;
        rst = 1'b0;
        idle();
        drive_alu(1'b0, 5'd0, '0);
        drive_ld(1'b0, 5'd0, '0);
        iss_rd = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b1;

        // ALU path
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("alu_rg",   64'(write_rg),   64'(5));
        check("alu_data", 64'(write_data), 64'(32'hDEADBEEF));
        idle();
        tick();
        check("alu_idle_w_en", 64'(w_en), 64'(0));

        // Contention: ALU owns the port for three cycles, then the load drains
        drive_alu(1'b1, 5'd3, 32'h0000_0033);
        drive_ld(1'b1, 5'd7, 32'h11);
        tick();
        check("cont_count", 64'(lq_count), 64'(1));
        ld_valid = 1'b0;
        tick();
        tick();
        alu_valid = 1'b0;
        tick();
        check("cont_rg",   64'(write_rg),   64'(7));
        check("cont_data", 64'(write_data), 64'(32'h11));
        check("cont_drain", 64'(lq_count),  64'(0));
        tick();

        // Full queue with ALU busy; fifth load waits for space
        drive_alu(1'b1, 5'd3, 32'h0000_0003);
        for (int i = 1; i <= 4; i++) begin
            drive_ld(1'b1, 5'(i), 32'h100 + i);
            tick();
        end
        drive_ld(1'b1, 5'd5, 32'h105);
        #1;
        check("full_flag",  64'(lq_full),  64'(1));
        check("full_ready", 64'(ld_ready), 64'(0));
        tick();
        alu_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) break;
        end
        check("fifth_accepted", 64'(last_acc), 64'(1));
        ld_valid = 1'b0;
        repeat (6) tick();

        // Scoreboard
        iss_valid = 1'b1; iss_rd = 5'd9; chk1_rg = 5'd9;
        tick();
        iss_valid = 1'b0;
        #1;
        check("sb_hazard", 64'(hazard), 64'(1));
        drive_ld(1'b1, 5'd9, 32'h99);
        tick();
        ld_valid = 1'b0;
        tick();
        #1;
        check("sb_outstage_hazard", 64'(hazard), 64'(1));
        tick();
        #1;
        check("sb_cleared", 64'(hazard), 64'(0));
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        drive_alu(1'b1, 5'd9, 32'h9999);
        tick();
        check("sb_set_wins", 64'(pend[9]), 64'(1));
        idle();
        drive_alu(1'b1, 5'd9, 32'h1);
        tick();
        idle();
        tick();

        // x0 destinations
        cnt_before = lq_count;
        drive_alu(1'b1, 5'd0, 32'hFFFF);
        drive_ld(1'b1, 5'd0, 32'hEEEE);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        check("x0_w_en",  64'(w_en),     64'(0));
        check("x0_pend0", 64'(pend[0]),  64'(0));
        check("x0_count", 64'(lq_count), 64'(cnt_before));
        idle();
        tick();

        // Reset mid-stream with two queued loads
        drive_alu(1'b1, 5'd2, 32'h22);
        iss_valid = 1'b1; iss_rd = 5'd12;
        drive_ld(1'b1, 5'd10, 32'hA0);
        tick();
        iss_valid = 1'b0;
        drive_ld(1'b1, 5'd11, 32'hB0);
        tick();
        idle();
        #1 rst = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        #1 rst = 1'b1;
        repeat (4) tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            alu_valid = ($urandom_range(0, 99) < 40);
            alu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 50);
            ld_rd     = 5'($urandom_range(0, 7));
            ld_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 40);
            iss_rd    = 5'($urandom_range(0, 7));
            chk1_rg   = 5'($urandom_range(0, 7));
            chk2_rg   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
